// File: rtl/parametrik_denetim_durum_birimi_if.sv
`default_nettype none
// ============================================================================
// Module      : parametrik_denetim_durum_birimi_if
// Description : Bundle of pipeline <-> hazard/forwarding controller signals.
//               slave  = the controller (reads pipeline state, drives controls)
//               master = the pipeline side (drives state, reads controls)
//               Port summary: GETIR mispredict/valid in, hold/flush out;
//               COZ source addresses/valids in, forward selects/hold/flush
//               out; YURUT done in, hold out; per-stage rd/write/ready in;
//               saturating stall/flush counters out.
// Revision    : 1.0 - initial release
// ============================================================================
interface parametrik_denetim_durum_birimi_if #(
  parameter int ADRES_BIT     = 5,
  parameter int KAYNAK_SAYISI = 2,
  parameter int ASAMA_SAYISI  = 2,
  parameter int SAYAC_BIT     = 16
);
  localparam int SEC_BIT = $clog2(ASAMA_SAYISI + 1);

  logic                                 gtr_yanlis_tahmin_i;
  logic                                 gtr_hazir_i;
  logic                                 gtr_durdur_o;
  logic                                 gtr_bosalt_o;
  logic [KAYNAK_SAYISI*ADRES_BIT-1:0]   cyo_rs_adres_i;
  logic [KAYNAK_SAYISI-1:0]             cyo_rs_gecerli_i;
  logic [KAYNAK_SAYISI*SEC_BIT-1:0]     cyo_yonlendir_sec_o;
  logic                                 cyo_durdur_o;
  logic                                 cyo_bosalt_o;
  logic                                 yrt_hazir_i;
  logic                                 yrt_durdur_o;
  logic [ASAMA_SAYISI-1:0]              asama_yaz_yazmac_i;
  logic [ASAMA_SAYISI*ADRES_BIT-1:0]    asama_rd_adres_i;
  logic [ASAMA_SAYISI-1:0]              asama_sonuc_hazir_i;
  logic [SAYAC_BIT-1:0]                 durdur_sayac_o;
  logic [SAYAC_BIT-1:0]                 bosalt_sayac_o;

  modport slave (
    input  gtr_yanlis_tahmin_i, gtr_hazir_i, cyo_rs_adres_i, cyo_rs_gecerli_i,
           yrt_hazir_i, asama_yaz_yazmac_i, asama_rd_adres_i, asama_sonuc_hazir_i,
    output gtr_durdur_o, gtr_bosalt_o, cyo_yonlendir_sec_o, cyo_durdur_o,
           cyo_bosalt_o, yrt_durdur_o, durdur_sayac_o, bosalt_sayac_o
  );

  modport master (
    output gtr_yanlis_tahmin_i, gtr_hazir_i, cyo_rs_adres_i, cyo_rs_gecerli_i,
           yrt_hazir_i, asama_yaz_yazmac_i, asama_rd_adres_i, asama_sonuc_hazir_i,
    input  gtr_durdur_o, gtr_bosalt_o, cyo_yonlendir_sec_o, cyo_durdur_o,
           cyo_bosalt_o, yrt_durdur_o, durdur_sayac_o, bosalt_sayac_o
  );
endinterface
`default_nettype wire

// File: rtl/parametrik_denetim_durum_birimi.sv
`default_nettype none
// ============================================================================
// Module      : parametrik_denetim_durum_birimi
// Description : Hazard/forwarding controller for the core pipeline.
//               Per-source forward selects (youngest valid producer wins),
//               load-use stall when that producer's result is not ready,
//               startup flush after reset and flush on mispredict, internal
//               per-stage bubble tracking, saturating stall/flush counters.
//               Ports: clk_i, rst_i (async, active-high) and the slave
//               modport of parametrik_denetim_durum_birimi_if.
// Revision    : 1.0 - initial release
// ============================================================================
module parametrik_denetim_durum_birimi #(
  parameter int ADRES_BIT        = 5,
  parameter int KAYNAK_SAYISI    = 2,
  parameter int ASAMA_SAYISI     = 2,
  parameter int BOS_BASLA_CEVRIM = 1,
  parameter int SAYAC_BIT        = 16
) (
  input  wire logic                        clk_i,
  input  wire logic                        rst_i,
  parametrik_denetim_durum_birimi_if.slave bus
);
  localparam int SEC_BIT = $clog2(ASAMA_SAYISI + 1);
  localparam int BOS_BIT = $clog2(BOS_BASLA_CEVRIM + 1);

  logic [ASAMA_SAYISI-1:0]          gecersiz_q, gecersiz_d;
  logic [BOS_BIT-1:0]               bos_sayac_q, bos_sayac_d;
  logic [SAYAC_BIT-1:0]             durdur_sayac_q, durdur_sayac_d;
  logic [SAYAC_BIT-1:0]             bosalt_sayac_q, bosalt_sayac_d;

  logic [KAYNAK_SAYISI*SEC_BIT-1:0] sec_w;
  logic                             hazard_ham_w;
  logic                             hazard_w;
  logic                             bosalt_w;
  logic                             ilerle_w;

  // Forward select and raw hazard. Stages are scanned oldest to youngest so
  // the youngest match overwrites; only that winner's readiness matters.
  always_comb begin
    sec_w        = '0;
    hazard_ham_w = 1'b0;
    for (int j = 0; j < KAYNAK_SAYISI; j++) begin : kaynak_tarama
      logic [ADRES_BIT-1:0] rs;
      logic [SEC_BIT-1:0]   sec_j;
      logic                 kazanan_hazir;
      rs            = bus.cyo_rs_adres_i[j*ADRES_BIT +: ADRES_BIT];
      sec_j         = '0;
      kazanan_hazir = 1'b1;
      for (int k = ASAMA_SAYISI - 1; k >= 0; k--) begin
        if (bus.cyo_rs_gecerli_i[j] && (rs != '0) && bus.asama_yaz_yazmac_i[k] &&
            (bus.asama_rd_adres_i[k*ADRES_BIT +: ADRES_BIT] == rs) && !gecersiz_q[k]) begin
          sec_j         = SEC_BIT'(k + 1);
          kazanan_hazir = bus.asama_sonuc_hazir_i[k];
        end
      end
      sec_w[j*SEC_BIT +: SEC_BIT] = sec_j;
      if (!kazanan_hazir) hazard_ham_w = 1'b1;
    end
  end

  // Flush dominates: a flushed instruction never stalls or counts as a hazard.
  assign bosalt_w = (bos_sayac_q != '0) | bus.gtr_yanlis_tahmin_i;
  assign hazard_w = hazard_ham_w & ~bosalt_w;
  assign ilerle_w = bus.gtr_hazir_i & bus.yrt_hazir_i;

  assign bus.cyo_yonlendir_sec_o = sec_w;
  assign bus.cyo_bosalt_o        = bosalt_w;
  assign bus.gtr_bosalt_o        = bosalt_w;
  assign bus.cyo_durdur_o        = ~bus.yrt_hazir_i | ~bus.gtr_hazir_i | hazard_w;
  assign bus.gtr_durdur_o        = ~bus.yrt_hazir_i | ~bus.gtr_hazir_i | hazard_w;
  assign bus.yrt_durdur_o        = ~bus.gtr_hazir_i;
  assign bus.durdur_sayac_o      = durdur_sayac_q;
  assign bus.bosalt_sayac_o      = bosalt_sayac_q;

  always_comb begin
    gecersiz_d     = gecersiz_q;
    bos_sayac_d    = bos_sayac_q;
    durdur_sayac_d = durdur_sayac_q;
    bosalt_sayac_d = bosalt_sayac_q;

    // A stalled or flushed COZ instruction enters YURUT as a bubble; older
    // validity bits simply follow the pipeline when it advances.
    if (ilerle_w) begin
      gecersiz_d[0] = bosalt_w | hazard_w;
      for (int k = 1; k < ASAMA_SAYISI; k++) begin
        gecersiz_d[k] = gecersiz_q[k-1];
      end
    end

    if (bos_sayac_q != '0) bos_sayac_d = bos_sayac_q - 1'b1;

    if (hazard_w && (durdur_sayac_q != '1))
      durdur_sayac_d = durdur_sayac_q + 1'b1;
    if (bus.gtr_yanlis_tahmin_i && (bosalt_sayac_q != '1))
      bosalt_sayac_d = bosalt_sayac_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gecersiz_q     <= '1;
      bos_sayac_q    <= BOS_BIT'(BOS_BASLA_CEVRIM);
      durdur_sayac_q <= '0;
      bosalt_sayac_q <= '0;
    end else begin
      gecersiz_q     <= gecersiz_d;
      bos_sayac_q    <= bos_sayac_d;
      durdur_sayac_q <= durdur_sayac_d;
      bosalt_sayac_q <= bosalt_sayac_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_parametrik_denetim_durum_birimi.sv
`default_nettype none
// ============================================================================
// Module      : tb_parametrik_denetim_durum_birimi
// Description : Directed, table-driven bench for the hazard/forwarding
//               controller (2 sources, 2 stages, 3 startup flush cycles,
//               2-bit counters), plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parametrik_denetim_durum_birimi;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  parametrik_denetim_durum_birimi_if #(
    .ADRES_BIT(5), .KAYNAK_SAYISI(2), .ASAMA_SAYISI(2), .SAYAC_BIT(2)
  ) bus ();

  parametrik_denetim_durum_birimi #(
    .ADRES_BIT(5), .KAYNAK_SAYISI(2), .ASAMA_SAYISI(2),
    .BOS_BASLA_CEVRIM(3), .SAYAC_BIT(2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rs_gec;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] yaz;
    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [1:0] hazir;
    logic       gtr_h;
    logic       yrt_h;
    logic [1:0] e_sec0;
    logic [1:0] e_sec1;
    logic       e_durdur;
    logic       e_yrt_durdur;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] rs_gec, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] yaz, input logic [4:0] rd0, input logic [4:0] rd1,
                       input logic [1:0] hazir, input logic gtr_h, input logic yrt_h,
                       input logic yt);
    bus.cyo_rs_gecerli_i    = rs_gec;
    bus.cyo_rs_adres_i      = {rs1, rs0};
    bus.asama_yaz_yazmac_i  = yaz;
    bus.asama_rd_adres_i    = {rd1, rd0};
    bus.asama_sonuc_hazir_i = hazir;
    bus.gtr_hazir_i         = gtr_h;
    bus.yrt_hazir_i         = yrt_h;
    bus.gtr_yanlis_tahmin_i = yt;
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 1'b1, 1'b1, 1'b0);
  endtask

  // Reset, release, then enough idle cycles for startup flush to end and
  // both stage validity bits to clear.
  task automatic do_reset();
    idle();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vt[0]  = '{2'b01, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b11, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0};
    vt[1]  = '{2'b01, 5'd5, 5'd0, 2'b11, 5'd5, 5'd5, 2'b11, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0};
    vt[2]  = '{2'b01, 5'd5, 5'd0, 2'b10, 5'd5, 5'd5, 2'b11, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0};
    vt[3]  = '{2'b01, 5'd5, 5'd0, 2'b11, 5'd9, 5'd5, 2'b11, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0};
    vt[4]  = '{2'b01, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
    vt[5]  = '{2'b00, 5'd5, 5'd0, 2'b11, 5'd5, 5'd5, 2'b00, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
    vt[6]  = '{2'b10, 5'd0, 5'd7, 2'b01, 5'd7, 5'd0, 2'b10, 1'b1, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0};
    vt[7]  = '{2'b01, 5'd3, 5'd0, 2'b11, 5'd3, 5'd3, 2'b01, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0};
    vt[8]  = '{2'b11, 5'd4, 5'd6, 2'b11, 5'd6, 5'd4, 2'b11, 1'b1, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0};
    vt[9]  = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1};
    vt[10] = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
    vt[11] = '{2'b10, 5'd0, 5'd8, 2'b10, 5'd0, 5'd8, 2'b01, 1'b1, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0};

    // ---- Reset state and startup flush (3 cycles) ----
    rst = 1'b1;
    drive(2'b01, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    #2;
    chk("rst_bosalt", bus.cyo_bosalt_o, 1);
    chk("rst_gtr_bosalt", bus.gtr_bosalt_o, 1);
    chk("rst_sec", bus.cyo_yonlendir_sec_o, 0);
    chk("rst_durdur", bus.cyo_durdur_o, 0);
    chk("rst_durdur_sayac", bus.durdur_sayac_o, 0);
    chk("rst_bosalt_sayac", bus.bosalt_sayac_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("start_bosalt_%0d", i), bus.cyo_bosalt_o, (i < 3) ? 1 : 0);
      chk($sformatf("start_sec_%0d", i), bus.cyo_yonlendir_sec_o, 0);
    end

    // ---- Table-driven single-cycle vectors, all stages valid ----
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rs_gec, vt[i].rs0, vt[i].rs1, vt[i].yaz, vt[i].rd0, vt[i].rd1,
            vt[i].hazir, vt[i].gtr_h, vt[i].yrt_h, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_sec0", i), bus.cyo_yonlendir_sec_o[1:0], vt[i].e_sec0);
      chk($sformatf("v%0d_sec1", i), bus.cyo_yonlendir_sec_o[3:2], vt[i].e_sec1);
      chk($sformatf("v%0d_cyo_durdur", i), bus.cyo_durdur_o, vt[i].e_durdur);
      chk($sformatf("v%0d_gtr_durdur", i), bus.gtr_durdur_o, vt[i].e_durdur);
      chk($sformatf("v%0d_yrt_durdur", i), bus.yrt_durdur_o, vt[i].e_yrt_durdur);
      chk($sformatf("v%0d_bosalt", i), bus.cyo_bosalt_o, 0);
      @(posedge clk); #1;
      idle();
      repeat (2) @(posedge clk);
      #1;
    end

    // ---- Load-use: one stall cycle, then bubble in stage 0 ----
    do_reset();
    drive(2'b10, 5'd0, 5'd7, 2'b01, 5'd7, 5'd0, 2'b10, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("lu_durdur", bus.cyo_durdur_o, 1);
    chk("lu_gtr_durdur", bus.gtr_durdur_o, 1);
    chk("lu_sec1", bus.cyo_yonlendir_sec_o[3:2], 1);
    @(posedge clk); #1;
    drive(2'b10, 5'd0, 5'd7, 2'b11, 5'd7, 5'd7, 2'b10, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("lu_bubble_sec1", bus.cyo_yonlendir_sec_o[3:2], 2);
    chk("lu_bubble_durdur", bus.cyo_durdur_o, 0);
    chk("lu_durdur_sayac", bus.durdur_sayac_o, 1);

    // ---- Mispredict with pending hazard ----
    @(posedge clk); #1;
    do_reset();
    drive(2'b10, 5'd0, 5'd7, 2'b01, 5'd7, 5'd0, 2'b10, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("mp_bosalt", bus.cyo_bosalt_o, 1);
    chk("mp_gtr_bosalt", bus.gtr_bosalt_o, 1);
    chk("mp_durdur", bus.cyo_durdur_o, 0);
    @(posedge clk); #1;
    drive(2'b10, 5'd0, 5'd7, 2'b01, 5'd7, 5'd0, 2'b11, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("mp_st0_flushed_sec1", bus.cyo_yonlendir_sec_o[3:2], 0);
    chk("mp_bosalt_after", bus.cyo_bosalt_o, 0);
    chk("mp_bosalt_sayac", bus.bosalt_sayac_o, 1);
    chk("mp_durdur_sayac", bus.durdur_sayac_o, 0);
    @(posedge clk); #1;
    drive(2'b10, 5'd0, 5'd7, 2'b10, 5'd0, 5'd7, 2'b11, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("mp_st1_flushed_sec1", bus.cyo_yonlendir_sec_o[3:2], 0);

    // ---- Counter saturation under fetch stall, then async reset ----
    @(posedge clk); #1;
    do_reset();
    drive(2'b10, 5'd0, 5'd7, 2'b01, 5'd7, 5'd0, 2'b10, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("sat_sayac_%0d", i), bus.durdur_sayac_o, (i < 3) ? i : 3);
      chk($sformatf("sat_durdur_%0d", i), bus.cyo_durdur_o, 1);
      chk($sformatf("sat_yrt_durdur_%0d", i), bus.yrt_durdur_o, 1);
      @(posedge clk);
    end
    #1;
    chk("sat_final", bus.durdur_sayac_o, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_durdur_sayac", bus.durdur_sayac_o, 0);
    chk("arst_bosalt", bus.cyo_bosalt_o, 1);
    chk("arst_sec", bus.cyo_yonlendir_sec_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
